// File: rtl/axis_demux_1_2.sv
// ---------------------------------------------------------------------------
// axis_demux_1_2
//   1-to-2 AXI-Stream packet router. The route of a packet is taken from sel
//   on its first beat and held until its last beat, so a packet never splits
//   across outputs. Each output owns a 2-entry {data,last} buffer, giving a
//   registered output path, 1-cycle latency and full throughput.
//
// Ports
//   clk, reset            clock (rising edge), async active-low reset
//   sel                   route for the next packet start (0 -> out 1, 1 -> out 2)
//   s_data/s_valid/s_last slave input beat, s_ready accept
//   m_*_1 / m_*_2         master outputs 1 and 2
//   pkt_cnt_1/pkt_cnt_2   packets fully delivered per output (wrapping)
//   busy                  high while a packet is in progress (FSM in PKT)
// ---------------------------------------------------------------------------

// Per-output 2-entry buffer with delivered-packet counter.
// ent0 is always the head; ent1 holds the second beat when count is 2.
module axis_demux_buf #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              full_o,
    output logic [CNT_W-1:0]  pkt_cnt_o
);
    logic [1:0]       cnt_q, cnt_d;
    logic [DATA_W:0]  ent0_q, ent0_d;
    logic [DATA_W:0]  ent1_q, ent1_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic             pop;

    assign pop = (cnt_q != 2'd0) && ready_i;

    always_comb begin
        cnt_d  = cnt_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        pkt_d  = pkt_q;
        case ({push_i, pop})
            2'b10: begin
                if (cnt_q == 2'd0) ent0_d = {last_i, data_i};
                else               ent1_d = {last_i, data_i};
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count unchanged; the incoming beat goes behind whatever
                // remains after the head leaves.
                if (cnt_q == 2'd1) begin
                    ent0_d = {last_i, data_i};
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = {last_i, data_i};
                end
            end
            default: ;
        endcase
        if (pop && ent0_q[DATA_W]) pkt_d = pkt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
            pkt_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            pkt_q  <= pkt_d;
        end
    end

    assign valid_o   = (cnt_q != 2'd0);
    assign data_o    = ent0_q[DATA_W-1:0];
    assign last_o    = ent0_q[DATA_W];
    assign full_o    = cnt_q[1];
    assign pkt_cnt_o = pkt_q;
endmodule

module axis_demux_1_2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    output logic [DATA_W-1:0] m_data_1,
    output logic              m_valid_1,
    input  logic              m_ready_1,
    output logic              m_last_1,
    output logic [DATA_W-1:0] m_data_2,
    output logic              m_valid_2,
    input  logic              m_ready_2,
    output logic              m_last_2,
    output logic [CNT_W-1:0]  pkt_cnt_1,
    output logic [CNT_W-1:0]  pkt_cnt_2,
    output logic              busy
);
    localparam int NUM_OUT = 2;

    typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_e;

    state_e state_q;
    logic   route_q;
    logic   target;
    logic   acc;

    logic [NUM_OUT-1:0]             push_v;
    logic [NUM_OUT-1:0]             ready_v;
    logic [NUM_OUT-1:0]             valid_v;
    logic [NUM_OUT-1:0]             last_v;
    logic [NUM_OUT-1:0]             full_v;
    logic [NUM_OUT-1:0][DATA_W-1:0] data_v;
    logic [NUM_OUT-1:0][CNT_W-1:0]  cnt_v;

    // sel only matters at a packet start; mid-packet the latched route wins.
    assign target = (state_q == IDLE) ? sel : route_q;

    // Held low during reset so nothing is accepted while buffers are flushed.
    assign s_ready = reset && !full_v[target];
    assign acc     = s_valid && s_ready;

    assign push_v  = {acc && target, acc && !target};
    assign ready_v = {m_ready_2, m_ready_1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            route_q <= 1'b0;
        end else if (acc) begin
            case (state_q)
                IDLE: begin
                    route_q <= sel;
                    state_q <= s_last ? IDLE : PKT;
                end
                PKT: begin
                    if (s_last) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        axis_demux_buf #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_buf (
            .clk       (clk),
            .rst_n     (reset),
            .push_i    (push_v[g]),
            .data_i    (s_data),
            .last_i    (s_last),
            .ready_i   (ready_v[g]),
            .valid_o   (valid_v[g]),
            .data_o    (data_v[g]),
            .last_o    (last_v[g]),
            .full_o    (full_v[g]),
            .pkt_cnt_o (cnt_v[g])
        );
    end

    assign m_data_1  = data_v[0];
    assign m_valid_1 = valid_v[0];
    assign m_last_1  = last_v[0];
    assign m_data_2  = data_v[1];
    assign m_valid_2 = valid_v[1];
    assign m_last_2  = last_v[1];
    assign pkt_cnt_1 = cnt_v[0];
    assign pkt_cnt_2 = cnt_v[1];
    assign busy      = (state_q == PKT);
endmodule

// File: tb/tb_axis_demux_1_2.sv
module tb_axis_demux_1_2;
    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [7:0]  m_data_1, m_data_2;
    logic        m_valid_1, m_valid_2;
    logic        m_ready_1, m_ready_2;
    logic        m_last_1, m_last_2;
    logic [15:0] pkt_cnt_1, pkt_cnt_2;
    logic        busy;

    int errs = 0;
    int chks = 0;
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    always #5 clk = ~clk;

    axis_demux_1_2 #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .sel(sel),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .m_data_1(m_data_1), .m_valid_1(m_valid_1), .m_ready_1(m_ready_1), .m_last_1(m_last_1),
        .m_data_2(m_data_2), .m_valid_2(m_valid_2), .m_ready_2(m_ready_2), .m_last_2(m_last_2),
        .pkt_cnt_1(pkt_cnt_1), .pkt_cnt_2(pkt_cnt_2), .busy(busy)
    );

    // Beats popped on each output, recorded as {last,data}. Inputs only move
    // just after posedge, so negedge values are those seen at the next edge.
    always @(negedge clk) begin
        if (reset && m_valid_1 && m_ready_1) q1.push_back({m_last_1, m_data_1});
        if (reset && m_valid_2 && m_ready_2) q2.push_back({m_last_2, m_data_2});
    end

    // Offer one beat starting at posedge+1; return at posedge+1 after it is taken.
    task automatic send(input logic [7:0] d, input logic l, input logic s, output int waited);
        s_valid = 1'b1; s_data = d; s_last = l; sel = s; waited = 0;
        #1;
        while (!s_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!s_ready) begin
            errs++;
            $display("FAIL send_timeout data=%0h s_ready=%b required 1", d, s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        reset = 1'b0; sel = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        m_ready_1 = 1'b1; m_ready_2 = 1'b1;
        #2;
        chks++;
        if ({s_ready, m_valid_1, m_valid_2, m_last_1, m_last_2, busy} !== 6'b0) begin
            errs++; $display("FAIL reset_ctrl got %b required 000000",
                             {s_ready, m_valid_1, m_valid_2, m_last_1, m_last_2, busy});
        end
        chks++;
        if ({m_data_1, m_data_2, pkt_cnt_1, pkt_cnt_2} !== 48'h0) begin
            errs++; $display("FAIL reset_data got %h required 0",
                             {m_data_1, m_data_2, pkt_cnt_1, pkt_cnt_2});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        int w;
        q1.delete(); q2.delete();
        sel = 1'b0;
        chks++;
        if (m_valid_1 !== 1'b0) begin errs++; $display("FAIL t1_pre_valid got %b required 0", m_valid_1); end
        for (int i = 0; i < 4; i++) begin
            send(8'h11 + 8'(i), i == 3, 1'b0, w);
            chks++;
            if ({m_valid_1, m_last_1, m_data_1, m_valid_2, busy} !== {1'b1, i == 3, 8'h11 + 8'(i), 1'b0, i != 3}) begin
                errs++;
                $display("FAIL t1_beat%0d got v=%b l=%b d=%h v2=%b busy=%b required v=1 l=%b d=%h v2=0 busy=%b",
                         i, m_valid_1, m_last_1, m_data_1, m_valid_2, busy, i == 3, 8'h11 + 8'(i), i != 3);
            end
        end
        idle(2);
        chks++;
        if ({pkt_cnt_1, m_valid_1, q2.size()} !== {16'd1, 1'b0, 32'd0}) begin
            errs++; $display("FAIL t1_end cnt1=%0d v1=%b q2=%0d required 1 0 0", pkt_cnt_1, m_valid_1, q2.size());
        end
    endtask

    task automatic test_sel_hold();
        int w;
        q1.delete(); q2.delete();
        send(8'h21, 1'b0, 1'b1, w);
        send(8'h22, 1'b0, 1'b0, w);
        send(8'h23, 1'b1, 1'b0, w);
        idle(3);
        chks++;
        if (q2.size() != 3 || q1.size() != 0) begin
            errs++; $display("FAIL t2_sizes q2=%0d q1=%0d required 3 0", q2.size(), q1.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                chks++;
                if (q2[i] !== {i == 2, 8'h21 + 8'(i)}) begin
                    errs++; $display("FAIL t2_beat%0d got %h required %h", i, q2[i], {i == 2, 8'h21 + 8'(i)});
                end
            end
        end
        chks++;
        if ({pkt_cnt_1, pkt_cnt_2} !== {16'd1, 16'd1}) begin
            errs++; $display("FAIL t2_cnt got %0d/%0d required 1/1", pkt_cnt_1, pkt_cnt_2);
        end
    endtask

    task automatic test_backpressure();
        int w;
        q1.delete(); q2.delete();
        m_ready_1 = 1'b0;
        send(8'h31, 1'b0, 1'b0, w);
        send(8'h32, 1'b0, 1'b0, w);
        s_valid = 1'b1; s_data = 8'h33; s_last = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chks++;
            if ({s_ready, m_valid_1, m_data_1} !== {1'b0, 1'b1, 8'h31}) begin
                errs++; $display("FAIL t3_stall%0d got rdy=%b v=%b d=%h required rdy=0 v=1 d=31",
                                 c, s_ready, m_valid_1, m_data_1);
            end
            @(posedge clk); #1;
        end
        m_ready_1 = 1'b1;
        send(8'h33, 1'b0, 1'b0, w);
        chks++;
        if (w != 1) begin errs++; $display("FAIL t3_wait got %0d required 1", w); end
        send(8'h34, 1'b1, 1'b0, w);
        idle(3);
        #1;
        chks++;
        if ({s_ready, pkt_cnt_1} !== {1'b1, 16'd2}) begin
            errs++; $display("FAIL t3_end rdy=%b cnt1=%0d required 1 2", s_ready, pkt_cnt_1);
        end
        chks++;
        if (q1.size() != 4) begin
            errs++; $display("FAIL t3_size got %0d required 4", q1.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                chks++;
                if (q1[i] !== {i == 3, 8'h31 + 8'(i)}) begin
                    errs++; $display("FAIL t3_beat%0d got %h required %h", i, q1[i], {i == 3, 8'h31 + 8'(i)});
                end
            end
        end
    endtask

    task automatic test_independence();
        int w;
        q1.delete(); q2.delete();
        m_ready_1 = 1'b0;
        send(8'h41, 1'b0, 1'b0, w);
        send(8'h42, 1'b1, 1'b0, w);
        for (int i = 0; i < 3; i++) begin
            send(8'h51 + 8'(i), i == 2, 1'b1, w);
            chks++;
            if (w != 0 || {m_valid_2, m_data_2, m_data_1} !== {1'b1, 8'h51 + 8'(i), 8'h41}) begin
                errs++; $display("FAIL t4_beat%0d wait=%0d v2=%b d2=%h d1=%h required 0 1 %h 41",
                                 i, w, m_valid_2, m_data_2, m_data_1, 8'h51 + 8'(i));
            end
        end
        m_ready_1 = 1'b1;
        idle(4);
        chks++;
        if (q1.size() != 2 || q2.size() != 3) begin
            errs++; $display("FAIL t4_sizes q1=%0d q2=%0d required 2 3", q1.size(), q2.size());
        end else begin
            chks++;
            if ({q1[0], q1[1], q2[2]} !== {9'h041, 9'h142, 9'h153}) begin
                errs++; $display("FAIL t4_order got %h %h %h required 041 142 153", q1[0], q1[1], q2[2]);
            end
        end
        chks++;
        if ({pkt_cnt_1, pkt_cnt_2} !== {16'd3, 16'd2}) begin
            errs++; $display("FAIL t4_cnt got %0d/%0d required 3/2", pkt_cnt_1, pkt_cnt_2);
        end
    endtask

    task automatic test_single_beat();
        int w;
        q1.delete(); q2.delete();
        for (int i = 0; i < 6; i++) begin
            send(8'h60 + 8'(i), 1'b1, i[0], w);
            chks++;
            if (busy !== 1'b0) begin errs++; $display("FAIL t5_busy%0d got %b required 0", i, busy); end
        end
        idle(3);
        chks++;
        if (q1.size() != 3 || q2.size() != 3) begin
            errs++; $display("FAIL t5_sizes q1=%0d q2=%0d required 3 3", q1.size(), q2.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                chks++;
                if ({q1[i], q2[i]} !== {1'b1, 8'h60 + 8'(2*i), 1'b1, 8'h61 + 8'(2*i)}) begin
                    errs++; $display("FAIL t5_pair%0d got %h %h required %h %h", i, q1[i], q2[i],
                                     {1'b1, 8'h60 + 8'(2*i)}, {1'b1, 8'h61 + 8'(2*i)});
                end
            end
        end
        chks++;
        if ({pkt_cnt_1, pkt_cnt_2} !== {16'd6, 16'd5}) begin
            errs++; $display("FAIL t5_cnt got %0d/%0d required 6/5", pkt_cnt_1, pkt_cnt_2);
        end
    endtask

    task automatic test_mid_reset();
        int w;
        m_ready_1 = 1'b0;
        send(8'h71, 1'b0, 1'b0, w);
        send(8'h72, 1'b0, 1'b0, w);
        s_valid = 1'b1; s_data = 8'h73;
        reset = 1'b0;
        #1;
        chks++;
        if ({s_ready, m_valid_1, m_valid_2, m_last_1, m_last_2, busy} !== 6'b0) begin
            errs++; $display("FAIL t6_ctrl got %b required 000000",
                             {s_ready, m_valid_1, m_valid_2, m_last_1, m_last_2, busy});
        end
        chks++;
        if ({m_data_1, m_data_2, pkt_cnt_1, pkt_cnt_2} !== 48'h0) begin
            errs++; $display("FAIL t6_data got %h required 0", {m_data_1, m_data_2, pkt_cnt_1, pkt_cnt_2});
        end
        #2;
        reset = 1'b1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        q1.delete(); q2.delete();
        m_ready_1 = 1'b1; m_ready_2 = 1'b1;
        send(8'h81, 1'b0, 1'b1, w);
        send(8'h82, 1'b1, 1'b1, w);
        idle(3);
        chks++;
        if (q1.size() != 0 || q2.size() != 2) begin
            errs++; $display("FAIL t6_sizes q1=%0d q2=%0d required 0 2", q1.size(), q2.size());
        end else begin
            chks++;
            if ({q2[0], q2[1]} !== {9'h081, 9'h182}) begin
                errs++; $display("FAIL t6_beats got %h %h required 081 182", q2[0], q2[1]);
            end
        end
        chks++;
        if ({pkt_cnt_1, pkt_cnt_2, busy} !== {16'd0, 16'd1, 1'b0}) begin
            errs++; $display("FAIL t6_cnt got %0d/%0d busy=%b required 0/1 0", pkt_cnt_1, pkt_cnt_2, busy);
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_basic();
        test_sel_hold();
        test_backpressure();
        test_independence();
        test_single_beat();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
